// File: rtl/glitch_sequencer.sv
// ---------------------------------------------------------------------------
// glitch_sequencer
//
// Generates a programmable train of glitch-enable pulses for a clock
// glitcher. The sequencer arms on a single-cycle request and then waits for
// a rising edge on the target trigger. After a programmable delay it emits
// `count` pulses of `width` cycles, with `gap` low cycles between them. It
// then signals completion for one cycle.
//
// Ports
//   clk      : system clock; all logic runs on its rising edge
//   rst      : synchronous, active-low reset
//   arm      : single-cycle request to latch the configuration and arm
//   abort    : synchronous cancel; returns to IDLE on the next edge
//   trigger  : target trigger, already synchronous to clk
//   delay    : cycles from trigger edge to first glitch    [DELAY_W]
//   width    : glitch pulse length in cycles (0 acts as 1) [PULSE_W]
//   gap      : low cycles between pulses (0 acts as 1)     [DELAY_W]
//   count    : pulses per trigger (0 acts as 1)            [PULSE_W]
//   glitch_o : registered glitch enable
//   armed_o  : registered, high while waiting for the trigger
//   busy_o   : registered, high whenever the sequencer is not idle
//   done_o   : registered one-cycle pulse on normal completion
//
// Timing model
//   Every output is a registered image of the state the FSM was in during
//   the previous cycle. Outputs therefore lag the state register by exactly
//   one edge. A trigger edge sampled at edge T produces the first glitch_o
//   high at edge T+1+delay.
//
//   abort and rst both force every output low on the very edge where they
//   are sampled, so no stale glitch or done pulse can leak out.
// ---------------------------------------------------------------------------
module glitch_sequencer #(
    parameter int DELAY_W = 16,
    parameter int PULSE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [DELAY_W-1:0] delay,
    input  logic [PULSE_W-1:0] width,
    input  logic [DELAY_W-1:0] gap,
    input  logic [PULSE_W-1:0] count,
    output logic               glitch_o,
    output logic               armed_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DELAY  = 3'd2,
        GLITCH = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [DELAY_W-1:0] D_ZERO = '0;
    localparam logic [DELAY_W-1:0] D_ONE  = DELAY_W'(1);
    localparam logic [PULSE_W-1:0] P_ZERO = '0;
    localparam logic [PULSE_W-1:0] P_ONE  = PULSE_W'(1);

    state_t state;
    state_t state_nxt;

    // Configuration captured at arm time.
    // width, gap and count are stored already normalised (0 becomes 1).
    // As a result, the counters below never need a special zero case.
    logic [DELAY_W-1:0] cfg_delay;
    logic [PULSE_W-1:0] cfg_width;
    logic [DELAY_W-1:0] cfg_gap;
    logic [PULSE_W-1:0] cfg_count;
    logic               load_cfg;

    // Down-counters.
    // delay_cnt is shared by the DELAY and GAP phases, since they never
    // overlap. Each counter stops at 1, where the phase ends, so it can
    // never wrap.
    logic [DELAY_W-1:0] delay_cnt;
    logic [DELAY_W-1:0] delay_cnt_nxt;
    logic [PULSE_W-1:0] width_cnt;
    logic [PULSE_W-1:0] width_cnt_nxt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [PULSE_W-1:0] pulse_cnt_nxt;

    // The previous-trigger copy resets to 1.
    // A trigger that is already high when the sequencer arms is then not
    // mistaken for a fresh edge.
    logic trig_q;
    logic trig_edge;

    logic glitch_d;
    logic armed_d;
    logic busy_d;
    logic done_d;

    assign trig_edge = trigger & ~trig_q;

    // State register, trigger history and output registers.
    // Outputs are registered from the current state, so they are glitch-free
    // and lag the state by one edge. Reset clears everything except the
    // trigger history, which is forced high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            trig_q   <= 1'b1;
            glitch_o <= 1'b0;
            armed_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            trig_q   <= trigger;
            glitch_o <= glitch_d;
            armed_o  <= armed_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end

    // Configuration latch and counters.
    // The configuration is only captured when an arm request is accepted in
    // IDLE. Outside that moment the config inputs are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_delay <= D_ZERO;
            cfg_width <= P_ZERO;
            cfg_gap   <= D_ZERO;
            cfg_count <= P_ZERO;
            delay_cnt <= D_ZERO;
            width_cnt <= P_ZERO;
            pulse_cnt <= P_ZERO;
        end else begin
            if (load_cfg) begin
                cfg_delay <= delay;
                cfg_width <= (width == P_ZERO) ? P_ONE : width;
                cfg_gap   <= (gap   == D_ZERO) ? D_ONE : gap;
                cfg_count <= (count == P_ZERO) ? P_ONE : count;
            end
            delay_cnt <= delay_cnt_nxt;
            width_cnt <= width_cnt_nxt;
            pulse_cnt <= pulse_cnt_nxt;
        end
    end

    // Next-state and counter logic.
    // abort overrides everything else, including arm and trigger. Each
    // phase ends when its counter reads 1, so a load value of N gives
    // exactly N cycles in that phase.
    always_comb begin
        state_nxt     = state;
        delay_cnt_nxt = delay_cnt;
        width_cnt_nxt = width_cnt;
        pulse_cnt_nxt = pulse_cnt;
        load_cfg      = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        load_cfg  = 1'b1;
                        state_nxt = ARMED;
                    end
                end

                ARMED: begin
                    if (trig_edge) begin
                        pulse_cnt_nxt = cfg_count;
                        if (cfg_delay == D_ZERO) begin
                            width_cnt_nxt = cfg_width;
                            state_nxt     = GLITCH;
                        end else begin
                            delay_cnt_nxt = cfg_delay;
                            state_nxt     = DELAY;
                        end
                    end
                end

                DELAY: begin
                    if (delay_cnt == D_ONE) begin
                        width_cnt_nxt = cfg_width;
                        state_nxt     = GLITCH;
                    end else begin
                        delay_cnt_nxt = delay_cnt - D_ONE;
                    end
                end

                GLITCH: begin
                    if (width_cnt == P_ONE) begin
                        if (pulse_cnt == P_ONE) begin
                            state_nxt = DONE;
                        end else begin
                            pulse_cnt_nxt = pulse_cnt - P_ONE;
                            delay_cnt_nxt = cfg_gap;
                            state_nxt     = GAP;
                        end
                    end else begin
                        width_cnt_nxt = width_cnt - P_ONE;
                    end
                end

                GAP: begin
                    if (delay_cnt == D_ONE) begin
                        width_cnt_nxt = cfg_width;
                        state_nxt     = GLITCH;
                    end else begin
                        delay_cnt_nxt = delay_cnt - D_ONE;
                    end
                end

                DONE: begin
                    state_nxt = IDLE;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output decode.
    // Outputs are decoded from the current state. abort masks them, so all
    // outputs drop on the same edge as the return to IDLE.
    always_comb begin
        glitch_d = 1'b0;
        armed_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (!abort) begin
            glitch_d = (state == GLITCH);
            armed_d  = (state == ARMED);
            busy_d   = (state != IDLE);
            done_d   = (state == DONE);
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_glitch_sequencer
//
// Directed bench for glitch_sequencer.
//
// Stimulus is applied before a rising edge. Outputs are sampled 1 time unit
// after that edge. Expected outputs are packed as {glitch, armed, busy, done}.
// An edge index k counts edges after the trigger edge T.
// ---------------------------------------------------------------------------
module tb_glitch_sequencer;

    localparam int DELAY_W = 16;
    localparam int PULSE_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               arm;
    logic               abort;
    logic               trigger;
    logic [DELAY_W-1:0] delay;
    logic [PULSE_W-1:0] width;
    logic [DELAY_W-1:0] gap;
    logic [PULSE_W-1:0] count;
    logic               glitch_o;
    logic               armed_o;
    logic               busy_o;
    logic               done_o;

    int checks = 0;
    int passes = 0;

    glitch_sequencer #(
        .DELAY_W(DELAY_W),
        .PULSE_W(PULSE_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .abort   (abort),
        .trigger (trigger),
        .delay   (delay),
        .width   (width),
        .gap     (gap),
        .count   (count),
        .glitch_o(glitch_o),
        .armed_o (armed_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    // Drive the control inputs, then advance one rising edge and settle.
    task automatic applyStimulus(input logic a, input logic ab, input logic t);
        arm     = a;
        abort   = ab;
        trigger = t;
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs against the expected packed value.
    task automatic checkOutput(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {glitch_o, armed_o, busy_o, done_o};
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%b expected=%b (glitch,armed,busy,done)",
                    tag, obs, exp);
    endtask

    // Arm with delay=5,width=2,gap=3,count=3, then fire one trigger edge.
    //
    // The optional disturbances must have no effect:
    //   - config inputs change after arming;
    //   - an arm pulse arrives during DELAY;
    //   - a second trigger edge arrives during GAP.
    task automatic runMainSequence(input bit disturb, input string tag);
        logic [3:0] exp;
        logic       t;
        logic       a;
        delay = 16'd5; width = 8'd2; gap = 16'd3; count = 8'd3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput({tag, "_arm_edge"}, 4'b0000);
        delay = 16'd1; width = 8'd7; gap = 16'd9; count = 8'd1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_armed"}, 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_trig_edge"}, 4'b0110);
        for (int k = 1; k <= 19; k++) begin
            t = 1'b1;
            a = 1'b0;
            if (disturb && k == 8) t = 1'b0;
            if (disturb && k == 2) a = 1'b1;
            exp[3] = (k == 6 || k == 7 || k == 11 || k == 12 || k == 16 || k == 17);
            exp[2] = 1'b0;
            exp[1] = (k <= 18);
            exp[0] = (k == 18);
            applyStimulus(a, 1'b0, t);
            checkOutput($sformatf("%s_T+%0d", tag, k), exp);
        end
        trigger = 1'b0;
    endtask

    initial begin
        rst = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        delay = '0; width = '0; gap = '0; count = '0;

        // Reset held for a few edges, with arm requested to show it is ignored
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_0", 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("reset_1", 4'b0000);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_after_reset", 4'b0000);

        // Main pulse train, then the same train with ignored disturbances
        runMainSequence(1'b0, "main");
        runMainSequence(1'b1, "disturbed");

        // All-zero fields: single 1-cycle glitch at T+1, done at T+2
        delay = '0; width = '0; gap = '0; count = '0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("zero_arm", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("zero_trig", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("zero_T+1", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zero_T+2", 4'b0011);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zero_T+3", 4'b0000);

        // Trigger already high at arm time must not fire
        delay = 16'd1; width = 8'd1; gap = 16'd1; count = 8'd1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("held_arm", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_1", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_2", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held_low", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_edge", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_T+1", 4'b0010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("held_T+2", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held_T+3", 4'b0011);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("held_T+4", 4'b0000);

        // Abort during the second pulse of a three-pulse train
        delay = 16'd1; width = 8'd2; gap = 16'd1; count = 8'd3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("abort_arm", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_trig", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_T+1", 4'b0010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_T+2", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_T+3", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_T+4", 4'b0010);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_T+5", 4'b0000);
        for (int k = 6; k <= 9; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("abort_quiet_T+%0d", k), 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("abort_rearm", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_rearmed", 4'b0110);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_from_armed", 4'b0000);

        // Abort beats arm in IDLE
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("abort_vs_arm_0", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_vs_arm_1", 4'b0000);

        // Reset during GLITCH: outputs drop at once and stay low
        delay = '0; width = 8'd4; gap = 16'd1; count = 8'd1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_arm", 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_trig", 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_T+1", 4'b1010);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_T+2", 4'b1010);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_mid", 4'b0000);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, k[0]);
            checkOutput($sformatf("rst_after_%0d", k), 4'b0000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter DELAY_W, default 16, width of delay and gap fields.
REQ-002 SHALL have parameter PULSE_W, default 8, width of width and count fields.
REQ-003 SHALL have port clk  input  1  system clock (48 MHz); all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port arm  input  1  single-cycle request to load configuration and arm.
REQ-006 SHALL have port abort  input  1  synchronous cancel of any sequence.
REQ-007 SHALL have port trigger  input  1  target trigger, already synchronous to clk.
REQ-008 SHALL have port delay  input  DELAY_W  clk cycles from trigger edge to first glitch.
REQ-009 SHALL have port width  input  PULSE_W  glitch pulse length in clk cycles.
REQ-010 SHALL have port gap  input  DELAY_W  low cycles between consecutive glitches.
REQ-011 SHALL have port count  input  PULSE_W  number of glitch pulses per trigger.
REQ-012 SHALL have port glitch_o  output  1  glitch enable to the clock glitcher, registered.
REQ-013 SHALL have port armed_o  output  1  high while waiting for trigger.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse when a sequence completes normally.

Function
REQ-016 SHALL implement states IDLE, ARMED, DELAY, GLITCH, GAP, DONE.
REQ-017 IDLE: arm=1 SHALL latch delay/width/gap/count into internal registers and enter ARMED next cycle; config inputs ignored afterwards.
REQ-018 arm SHALL be ignored in every state except IDLE.
REQ-019 Latched width, gap and count of 0 SHALL each be treated as 1.
REQ-020 ARMED: rising edge = trigger 1 this cycle and 0 in previous cycle (registered copy, reset to 1 so a held-high trigger at arming does not fire).
REQ-021 Edge sampled at cycle T SHALL make glitch_o first high at T+1+delay; delay=0 enters GLITCH directly.
REQ-022 GLITCH: glitch_o SHALL be high for exactly width cycles, then remaining-pulse counter decrements.
REQ-023 After a pulse with remaining count nonzero SHALL enter GAP, holding glitch_o low exactly gap cycles, then GLITCH.
REQ-024 After the last pulse SHALL enter DONE for one cycle (done_o=1), then IDLE.
REQ-025 Trigger edges during DELAY, GLITCH, GAP, DONE SHALL be ignored (no retrigger, no queueing).
REQ-026 abort=1 in any state SHALL return to IDLE next cycle, glitch_o=0 next cycle, no done_o; abort wins over arm and trigger in the same cycle.
REQ-027 Counters SHALL be down-counters of the field width; no wrap-around beyond the loaded value.
REQ-028 glitch_o, armed_o, busy_o, done_o SHALL be registered outputs, glitch-free.

Reset
REQ-029 rst low at a clock edge SHALL force IDLE, clear latched config and counters, set previous-trigger register to 1.
REQ-030 During and after reset all outputs SHALL be 0 until arm is accepted.
REQ-031 Reset mid-sequence SHALL drop glitch_o to 0 on the same edge, with no done_o.

Verification
REQ-032 arm with delay=5,width=2,gap=3,count=3; trigger rises at cycle T -> glitch_o high T+6..T+7, T+11..T+12, T+16..T+17; done_o at T+18; busy_o low T+19.
REQ-033 delay=0,width=0,count=0 -> single 1-cycle glitch_o at T+1, done_o at T+2.
REQ-034 trigger held high when arm accepted -> no glitch until trigger goes low then high again.
REQ-035 abort asserted during second pulse of count=3 -> glitch_o low next cycle, state IDLE, done_o never asserted, new arm accepted.
REQ-036 second trigger edge during GAP and arm pulse during DELAY -> ignored; pulse timing identical to REQ-032.
REQ-037 rst low during GLITCH -> glitch_o 0 at that edge, all outputs 0, armed_o stays 0 until next arm.
